// File: rtl/four_by_four_ram_ctrl_if.sv
// Request/response handshake bundle between a requester and the 4x4 RAM controller.
// The master drives requests and accepts responses; the slave is the controller.
interface four_by_four_ram_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [1:0] req_addr;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_wr;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_wr
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_wr
  );
endinterface

// File: rtl/four_by_four_ram_ctrl.sv
// Controller for a 4-word x 4-bit RAM: optional zero-fill after reset, then one
// read or write per request with multi-cycle RAM access and a held response.
module four_by_four_ram_ctrl #(
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 1,
  parameter bit          INIT_EN   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  four_by_four_ram_ctrl_if.slave   bus,
  output logic                     mem_en,
  output logic                     rd_wr,
  output logic [1:0]               addr,
  output logic [3:0]               wr_data,
  input  logic [3:0]               rd_data
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 4;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                op_wr, op_wr_n;
  logic                mem_en_n, rd_wr_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wr_data_n;
  logic                req_ready_q, req_ready_n;
  logic                rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_n;
  logic                rsp_wr_q, rsp_wr_n;
  logic [CNT_W-1:0]    last_cnt;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_wr    = rsp_wr_q;

  assign last_cnt = op_wr ? CNT_W'(WR_CYCLES - 1) : CNT_W'(RD_CYCLES - 1);

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      mem_en      <= 1'b0;
      rd_wr       <= 1'b1;
      addr        <= '0;
      wr_data     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_wr_q    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      op_wr       <= op_wr_n;
      mem_en      <= mem_en_n;
      rd_wr       <= rd_wr_n;
      addr        <= addr_n;
      wr_data     <= wr_data_n;
      req_ready_q <= req_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      rsp_wr_q    <= rsp_wr_n;
    end
  end

  // Next state and next output values
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    op_wr_n     = op_wr;
    mem_en_n    = mem_en;
    rd_wr_n     = rd_wr;
    addr_n      = addr;
    wr_data_n   = wr_data;
    req_ready_n = req_ready_q;
    rsp_valid_n = rsp_valid_q;
    rsp_data_n  = rsp_data_q;
    rsp_wr_n    = rsp_wr_q;

    case (state)
      ST_INIT: begin
        req_ready_n = 1'b0;
        // mem_en still low means this is the cycle right after reset
        if (!mem_en) begin
          mem_en_n  = 1'b1;
          rd_wr_n   = 1'b0;
          addr_n    = '0;
          wr_data_n = '0;
          cnt_n     = '0;
        end else if (cnt == CNT_W'(WR_CYCLES - 1)) begin
          cnt_n = '0;
          if (addr == ADDR_W'(3)) begin
            state_n     = ST_IDLE;
            mem_en_n    = 1'b0;
            rd_wr_n     = 1'b1;
            req_ready_n = 1'b1;
          end else begin
            addr_n = addr + ADDR_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        mem_en_n    = 1'b0;
        rd_wr_n     = 1'b1;
        req_ready_n = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          state_n     = ST_ACCESS;
          op_wr_n     = bus.req_wr;
          cnt_n       = '0;
          mem_en_n    = 1'b1;
          rd_wr_n     = !bus.req_wr;
          addr_n      = bus.req_addr;
          req_ready_n = 1'b0;
          if (bus.req_wr) wr_data_n = bus.req_wdata;
        end
      end

      ST_ACCESS: begin
        // rd_data is only looked at here, on the last cycle of a read
        if (cnt == last_cnt) begin
          state_n     = ST_RESP;
          cnt_n       = '0;
          mem_en_n    = 1'b0;
          rd_wr_n     = 1'b1;
          rsp_valid_n = 1'b1;
          rsp_wr_n    = op_wr;
          rsp_data_n  = op_wr ? DATA_W'(0) : rd_data;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b0;
          req_ready_n = 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_four_by_four_ram_ctrl.sv
// Self-checking bench: default controller against a word-array RAM model, plus a
// second instance (no init, slow reads) against a RAM whose data is valid late.
module tb_four_by_four_ram_ctrl;
  localparam int unsigned WR1 = 2, RD1 = 1, WR2 = 1, RD2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  int checks, errors;
  logic [3:0] model [4];

  four_by_four_ram_ctrl_if bus1 ();
  four_by_four_ram_ctrl_if bus2 ();

  logic       mem_en1, rd_wr1, mem_en2, rd_wr2;
  logic [1:0] addr1, addr2;
  logic [3:0] wr_data1, rd_data1, wr_data2, rd_data2;

  four_by_four_ram_ctrl dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .mem_en(mem_en1), .rd_wr(rd_wr1),
    .addr(addr1), .wr_data(wr_data1), .rd_data(rd_data1)
  );

  four_by_four_ram_ctrl #(.WR_CYCLES(WR2), .RD_CYCLES(RD2), .INIT_EN(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2), .mem_en(mem_en2), .rd_wr(rd_wr2),
    .addr(addr2), .wr_data(wr_data2), .rd_data(rd_data2)
  );

  // RAM models: wrong (inverted) data whenever a sample would be illegal
  logic [3:0] ram1 [4] = '{4'h5, 4'h6, 4'h7, 4'h9};
  logic [3:0] ram2 [4] = '{4'h3, 4'hC, 4'h6, 4'hA};
  logic [2:0] rd_cnt2 = 3'd0;

  always @(posedge clk) if (mem_en1 && !rd_wr1) ram1[addr1] <= wr_data1;
  always @(posedge clk) if (mem_en2 && !rd_wr2) ram2[addr2] <= wr_data2;
  always @(posedge clk) rd_cnt2 <= (mem_en2 && rd_wr2) ? rd_cnt2 + 3'd1 : 3'd0;

  assign rd_data1 = (mem_en1 && rd_wr1) ? ram1[addr1] : ~ram1[addr1];
  assign rd_data2 = (mem_en2 && rd_wr2 && rd_cnt2 == 3'd2) ? ram2[addr2] : ~ram2[addr2];

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({mem_en1, rd_wr1, addr1, wr_data1, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_wr, bus1.req_ready}
        !== {1'b0, 1'b1, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: mem_en=%b rd_wr=%b addr=%0d wr_data=%h rsp_valid=%b rsp_data=%h rsp_wr=%b req_ready=%b (exp 0 1 0 0 0 0 0 0)",
               mem_en1, rd_wr1, addr1, wr_data1, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_wr, bus1.req_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_en1, rd_wr1, addr1, wr_data1, bus1.req_ready} !== {1'b1, 1'b0, 2'(i / 2), 4'd0, 1'b0}) begin
        errors++;
        $display("FAIL init_cycle%0d: mem_en=%b rd_wr=%b addr=%0d wr_data=%h req_ready=%b exp addr=%0d",
                 i, mem_en1, rd_wr1, addr1, wr_data1, bus1.req_ready, i / 2);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus1.req_ready, mem_en1} !== 2'b10) begin
      errors++;
      $display("FAIL init_done: req_ready=%b mem_en=%b exp 1 0", bus1.req_ready, mem_en1);
    end
    for (int i = 0; i < 4; i++) model[i] = 4'd0;
  endtask

  task automatic txn(input bit wr, input logic [1:0] a, input logic [3:0] d, input int stall);
    int n;
    int exp_lat;
    logic [3:0] exp_data;
    exp_lat = 1 + int'(wr ? WR1 : RD1);
    bus1.req_valid = 1'b1; bus1.req_wr = wr; bus1.req_addr = a; bus1.req_wdata = d;
    bus1.rsp_ready = (stall == 0);
    n = 0;
    while (bus1.req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles exp 1", bus1.req_ready, n);
      bus1.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus1.req_valid = 1'b0; bus1.req_wr = 1'($urandom); bus1.req_addr = 2'($urandom);
    bus1.req_wdata = 4'($urandom);
    checks++;
    if ({bus1.req_ready, mem_en1, rd_wr1, addr1} !== {1'b0, 1'b1, !wr, a}) begin
      errors++;
      $display("FAIL access_start: req_ready=%b mem_en=%b rd_wr=%b addr=%0d exp 0 1 %b %0d",
               bus1.req_ready, mem_en1, rd_wr1, addr1, !wr, a);
    end
    if (wr) begin
      checks++;
      if (wr_data1 !== d) begin
        errors++;
        $display("FAIL access_wdata: wr_data=%h exp %h", wr_data1, d);
      end
    end
    n = 1;
    while (bus1.rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d cycles exp %0d (wr=%b)", n, exp_lat, wr);
    end
    if (wr) begin model[a] = d; exp_data = 4'd0; end
    else exp_data = model[a];
    checks++;
    if ({bus1.rsp_data, bus1.rsp_wr, mem_en1} !== {exp_data, wr, 1'b0}) begin
      errors++;
      $display("FAIL response: rsp_data=%h rsp_wr=%b mem_en=%b exp %h %b 0 (addr %0d)",
               bus1.rsp_data, bus1.rsp_wr, mem_en1, exp_data, wr, a);
    end
    for (int i = 0; i < stall; i++) begin
      bus1.req_valid = 1'b1; bus1.req_wr = 1'b1; bus1.req_addr = a + 2'd1;
      bus1.req_wdata = ~model[a + 2'd1];
      @(posedge clk); #1;
      checks++;
      if ({bus1.rsp_valid, bus1.rsp_data, mem_en1, bus1.req_ready} !== {1'b1, exp_data, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall%0d: rsp_valid=%b rsp_data=%h mem_en=%b req_ready=%b exp 1 %h 0 0",
                 i, bus1.rsp_valid, bus1.rsp_data, mem_en1, bus1.req_ready, exp_data);
      end
    end
    bus1.req_valid = 1'b0;
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus1.rsp_valid, bus1.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rsp_handshake: rsp_valid=%b req_ready=%b exp 0 1", bus1.rsp_valid, bus1.req_ready);
    end
  endtask

  task automatic test_init_zero();
    for (int a = 0; a < 4; a++) txn(1'b0, 2'(a), 4'd0, 0);
  endtask

  task automatic test_write_read();
    txn(1'b1, 2'd2, 4'b1011, 0);
    txn(1'b0, 2'd2, 4'd0, 0);
  endtask

  task automatic test_walking();
    for (int a = 0; a < 4; a++) txn(1'b1, 2'(a), 4'(1 << a), 0);
    for (int a = 3; a >= 0; a--) txn(1'b0, 2'(a), 4'd0, 0);
  endtask

  task automatic test_stall();
    txn(1'b0, 2'd2, 4'd0, 5);
  endtask

  task automatic test_reset_mid_access();
    bus1.req_valid = 1'b1; bus1.req_wr = 1'b1; bus1.req_addr = 2'd1; bus1.req_wdata = 4'hE;
    bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus1.rsp_valid, mem_en1, rd_wr1, addr1, bus1.req_ready} !== {1'b0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL abort_reset: rsp_valid=%b mem_en=%b rd_wr=%b addr=%0d req_ready=%b exp 0 0 1 0 0",
               bus1.rsp_valid, mem_en1, rd_wr1, addr1, bus1.req_ready);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({bus1.rsp_valid, mem_en1, addr1} !== {1'b0, 1'b1, 2'(i / 2)}) begin
        errors++;
        $display("FAIL reinit_cycle%0d: rsp_valid=%b mem_en=%b addr=%0d exp 0 1 %0d",
                 i, bus1.rsp_valid, mem_en1, addr1, i / 2);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({bus1.rsp_valid, bus1.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reinit_done: rsp_valid=%b req_ready=%b exp 0 1", bus1.rsp_valid, bus1.req_ready);
    end
    for (int i = 0; i < 4; i++) model[i] = 4'd0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      txn(1'($urandom), 2'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
  endtask

  task automatic test_slow_read();
    logic [3:0] m2 [4];
    logic [3:0] d, exp_data;
    logic [1:0] a;
    bit wr;
    int n, exp_lat;
    m2 = '{4'h3, 4'hC, 4'h6, 4'hA};
    bus2.req_valid = 1'b0; bus2.rsp_ready = 1'b1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus2.req_ready, mem_en2, bus2.rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL noinit_reset: req_ready=%b mem_en=%b rsp_valid=%b exp 0 0 0",
               bus2.req_ready, mem_en2, bus2.rsp_valid);
    end
    rst2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({bus2.req_ready, mem_en2} !== 2'b10) begin
      errors++;
      $display("FAIL noinit_ready: req_ready=%b mem_en=%b exp 1 0", bus2.req_ready, mem_en2);
    end
    for (int k = 0; k < 7; k++) begin
      wr = (k < 3);
      a  = (k < 3) ? 2'(k) : 2'(k - 3);
      d  = 4'($urandom);
      exp_lat = 1 + int'(wr ? WR2 : RD2);
      bus2.req_valid = 1'b1; bus2.req_wr = wr; bus2.req_addr = a; bus2.req_wdata = d;
      n = 0;
      while (bus2.req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      bus2.req_valid = 1'b0;
      n = 1;
      while (bus2.rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      if (wr) begin m2[a] = d; exp_data = 4'd0; end
      else exp_data = m2[a];
      checks++;
      if (n != exp_lat || bus2.rsp_data !== exp_data || bus2.rsp_wr !== wr) begin
        errors++;
        $display("FAIL slow_txn%0d: latency=%0d rsp_data=%h rsp_wr=%b exp %0d %h %b",
                 k, n, bus2.rsp_data, bus2.rsp_wr, exp_lat, exp_data, wr);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; rst2 = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_wr = 1'b0; bus1.req_addr = 2'd0; bus1.req_wdata = 4'd0;
    bus1.rsp_ready = 1'b1;
    bus2.req_valid = 1'b0; bus2.req_wr = 1'b0; bus2.req_addr = 2'd0; bus2.req_wdata = 4'd0;
    bus2.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = 4'd0;
    test_reset();
    test_init_zero();
    test_write_read();
    test_walking();
    test_stall();
    test_reset_mid_access();
    test_random();
    test_slow_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/four_by_four_ram_ctrl.md
FOUR_BY_FOUR_RAM_CTRL -- requirements
Module: four_by_four_ram_ctrl

Interface
REQ-001 Parameter WR_CYCLES, default 2: cycles mem_en is held with rd_wr=0 per write (legal 1..7).
REQ-002 Parameter RD_CYCLES, default 1: cycles mem_en is held with rd_wr=1 per read before rd_data is sampled (legal 1..7).
REQ-003 Parameter INIT_EN, default 1: when 1, the block zero-fills all four RAM words after reset.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept a request this cycle.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  2  word address.
REQ-010 req_wdata  input  4  write data.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  requester accepts response.
REQ-013 rsp_data  output  4  read data; 4'b0000 for write responses.
REQ-014 rsp_wr  output  1  response belongs to a write.
REQ-015 mem_en  output  1  RAM enable.
REQ-016 rd_wr  output  1  RAM direction: 1 = read, 0 = write.
REQ-017 addr  output  2  RAM address.
REQ-018 wr_data  output  4  RAM write data.
REQ-019 rd_data  input  4  RAM read data; high-Z when the RAM is not reading, which the block shall never sample.

Function
REQ-020 The block shall implement states INIT, IDLE, ACCESS and RESP; all outputs shall be registered.
REQ-021 INIT: mem_en=1, rd_wr=0, wr_data=0, addr steps 0,1,2,3; each address is held WR_CYCLES cycles; after address 3 the block goes to IDLE; req_ready=0 throughout.
REQ-022 IDLE: req_ready=1, mem_en=0, rd_wr=1, addr and wr_data hold their last values.
REQ-023 Handshake: on a cycle with req_valid=1 and req_ready=1, the block shall latch req_wr, req_addr and req_wdata, drop req_ready on the next edge, and enter ACCESS; req_* shall be ignored in all other cycles.
REQ-024 ACCESS write: mem_en=1, rd_wr=0, addr and wr_data from latched values for exactly WR_CYCLES cycles, then RESP.
REQ-025 ACCESS read: mem_en=1, rd_wr=1, addr latched for exactly RD_CYCLES cycles; rd_data shall be captured on the final ACCESS edge; then RESP.
REQ-026 On leaving ACCESS, mem_en shall return to 0 on the same edge that raises rsp_valid.
REQ-027 RESP: rsp_valid=1; rsp_data and rsp_wr stable until rsp_valid=1 and rsp_ready=1 coincide, then IDLE on the next edge.
REQ-028 Latency with rsp_ready tied 1: accept edge to rsp_valid high is 1+WR_CYCLES cycles for writes and 1+RD_CYCLES cycles for reads.
REQ-029 Back-to-back: a new request shall not be accepted in the same cycle as a response handshake; the minimum request-to-request spacing is 2+WR/RD_CYCLES cycles.
REQ-030 Per-state cycle counter shall be 3 bits; the INIT address counter shall be 2 bits and shall not wrap past 3 back into INIT.
REQ-031 rsp_ready held 0 indefinitely shall stall in RESP with no RAM activity and req_ready=0.

Reset
REQ-032 On rst=1 at a clock edge, the block shall go to INIT (INIT_EN=1) or IDLE (INIT_EN=0), with mem_en=0, rd_wr=1, addr=0, wr_data=0, rsp_valid=0, rsp_data=0, rsp_wr=0, req_ready=0 in the first cycle after reset.
REQ-033 Reset asserted mid-INIT, mid-ACCESS or in RESP shall abort the operation and drop any pending response; a write in progress may be left partially applied.
REQ-034 When INIT_EN=0, req_ready shall rise one cycle after rst deasserts.

Verification
REQ-035 Reset then INIT with defaults: addr 0,0,1,1,2,2,3,3 with mem_en=1 and rd_wr=0 over 8 cycles, then req_ready=1; reads of all words return 4'b0000.
REQ-036 Write addr 2 data 4'b1011, then read addr 2: write rsp_wr=1 with rsp_data=0 at accept+3; read rsp_data=4'b1011 at accept+2.
REQ-037 Writes of 4'h1, 4'h2, 4'h4, 4'h8 to addrs 0-3, then reads 3,2,1,0: responses are 8,4,2,1; no cross-word corruption.
REQ-038 Read response with rsp_ready=0 for 5 cycles: rsp_valid and rsp_data stable, mem_en=0, req_valid=1 is not accepted; acceptance occurs 2 cycles after rsp_ready rises.
REQ-039 rst pulsed during ACCESS of a write: rsp_valid never rises for that request; INIT restarts at addr 0.
REQ-040 RD_CYCLES=3 with a RAM model that is valid only at the end of the 3rd cycle: returns correct data; rd_data is never sampled while mem_en=0.
